// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART stream transmitter
// Contents: transmitter state enum, DATA_BITS, default bit period for 100 MHz / 115200 baud.
package uart_pkg;

    localparam int CLK_FREQ  = 100_000_000;
    localparam int BAUD      = 115200;
    localparam int DATA_BITS = 8;

    // Rounded to nearest: 100e6 / 115200 = 868.05 -> 868
    localparam int DEFAULT_CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_stream_tx_if.sv
// rtl/uart_stream_tx_if.sv - byte handshake between a stream source and the UART transmitter
// Signals: message (byte), start (request), ready (transmitter idle), done (frame finished pulse).
// Modports: master = byte source, slave = transmitter.
interface uart_stream_tx_if;

    logic [7:0] message;
    logic       start;
    logic       ready;
    logic       done;

    modport master (
        output message,
        output start,
        input  ready,
        input  done
    );

    modport slave (
        input  message,
        input  start,
        output ready,
        output done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing one bit_tick per CLKS_PER_BIT cycles
// Ports: clk, rst (async, active-high), clear (restart period), enable (count), bit_tick (last cycle of a bit).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Held at zero while disabled so every bit starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_stream_tx.sv
// rtl/uart_stream_tx.sv - 8N1 UART transmitter fed by a start/ready byte handshake
// Ports: clk, rst (async, active-high), s (slave handshake: message/start/ready/done), tx (serial line, idle high).
// Parameters: CLKS_PER_BIT (2..65535), STOP_BITS (1 or 2).
module uart_stream_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_stream_tx_if.slave   s,
    output logic              tx
);

    uart_state_t state;
    uart_state_t state_next;

    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic                 tx_q;
    logic                 bit_tick;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;

    assign accept    = (state == IDLE) && s.start;
    assign last_data = (bit_idx == 3'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .enable   (state != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)                 state_next = START;
            START:   if (bit_tick)               state_next = DATA;
            DATA:    if (bit_tick && last_data)  state_next = STOP;
            STOP:    if (bit_tick && last_stop)  state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // tx is registered and only moves on accept or a bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
        end else if (accept) begin
            shreg    <= s.message;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b0;
        end else if (bit_tick) begin
            case (state)
                START: tx_q <= shreg[0];
                DATA: begin
                    // shreg[1] is the bit that becomes shreg[0] after this shift.
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    tx_q    <= last_data ? 1'b1 : shreg[1];
                end
                STOP:    stop_idx <= stop_idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign tx      = tx_q;
    assign s.ready = (state == IDLE);
    assign s.done  = (state == STOP) && bit_tick && last_stop;

endmodule

// File: tb/tb_uart_stream_tx.sv
// tb/tb_uart_stream_tx.sv - self-checking bench for uart_stream_tx (1 and 2 stop bits, CLKS_PER_BIT=16)
module tb_uart_stream_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] message = 8'h00;
    logic       tx1, tx2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_stream_tx_if if1();
    uart_stream_tx_if if2();

    assign if1.start   = start;
    assign if1.message = message;
    assign if2.start   = start;
    assign if2.message = message;

    uart_stream_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk (clk), .rst (rst), .s (if1), .tx (tx1)
    );

    uart_stream_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk (clk), .rst (rst), .s (if2), .tx (tx2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: each accepted byte becomes a list of per-cycle {tx, done}
    // samples built from the frame layout (start, 8 data LSB first, stop bits).
    bit [1:0] q1[$];
    bit [1:0] q2[$];
    bit rdy1 = 1'b0;
    bit rdy2 = 1'b0;
    int acc1 = 0, acc2 = 0;
    int acc1_cyc = 0, acc1_prev = 0, acc2_cyc = 0, acc2_prev = 0;

    function automatic bit slot_level(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            if (start && rdy1) begin
                acc1++;
                acc1_prev = acc1_cyc;
                acc1_cyc  = cyc;
                for (int k = 0; k < 10; k++)
                    for (int c = 0; c < CPB; c++)
                        q1.push_back({slot_level(k, message), (k == 9 && c == CPB - 1)});
            end
            if (start && rdy2) begin
                acc2++;
                acc2_prev = acc2_cyc;
                acc2_cyc  = cyc;
                for (int k = 0; k < 11; k++)
                    for (int c = 0; c < CPB; c++)
                        q2.push_back({slot_level(k, message), (k == 10 && c == CPB - 1)});
            end
        end
    end

    always @(negedge clk) begin
        bit [1:0] smp;
        if (q1.size() > 0) begin
            smp  = q1.pop_front();
            rdy1 = 1'b0;
        end else begin
            smp  = 2'b10;
            rdy1 = 1'b1;
        end
        check("d1_tx", tx1, smp[1]);
        check("d1_done", if1.done, smp[0]);
        check("d1_ready", if1.ready, rdy1);
        if (q2.size() > 0) begin
            smp  = q2.pop_front();
            rdy2 = 1'b0;
        end else begin
            smp  = 2'b10;
            rdy2 = 1'b1;
        end
        check("d2_tx", tx2, smp[1]);
        check("d2_done", if2.done, smp[0]);
        check("d2_ready", if2.ready, rdy2);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rdy1 && rdy2) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) check("idle_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_idle();
        message = b;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        int a1, a2, n;

        // Reset and quiet line
        repeat (3) step();
        rst = 1'b0;
        repeat (200) step();

        // Single byte, then explicit 0x81 (second DUT shows 2 stop bits)
        send_byte(8'hA4);
        send_byte(8'h81);

        // Start while busy is ignored
        a1 = acc1;
        send_byte(8'h55);
        repeat (50) step();
        message = 8'hFF;
        start   = 1'b1;
        step();
        start   = 1'b0;
        wait_idle();
        check("busy_ignored", acc1 - a1, 1);
        repeat (20) step();

        // Back-to-back with start held high
        wait_idle();
        a1 = acc1;
        a2 = acc2;
        message = 8'h00;
        start   = 1'b1;
        n = 0;
        while (acc1 != a1 + 1 && n < 500) begin step(); n++; end
        message = 8'hFF;
        while (!(acc1 == a1 + 2 && acc2 == a2 + 2) && n < 1000) begin step(); n++; end
        start = 1'b0;
        check("b2b_timeout", (n < 1000), 1);
        check("b2b_gap1", acc1_cyc - acc1_prev, (9 + 1) * CPB + 1);
        check("b2b_gap2", acc2_cyc - acc2_prev, (9 + 2) * CPB + 1);
        wait_idle();

        // Asynchronous reset during data bit 3
        send_byte(8'h0F);
        repeat (70) step();
        check("rst_busy", if1.ready, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_async_tx1", tx1, 1);
        check("rst_async_rdy1", if1.ready, 1);
        check("rst_async_done1", if1.done, 0);
        check("rst_async_tx2", tx2, 1);
        check("rst_async_rdy2", if2.ready, 1);
        step();
        step();
        rst = 1'b0;
        send_byte(8'h0F);

        // Randomized bytes with ignored mid-frame requests and message churn
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 5)) step();
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(1, 40)) step();
                message = 8'($urandom);
                start   = 1'b1;
                step();
                start   = 1'b0;
            end
        end
        wait_idle();
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
